// File: rtl/kd_tree_sched.sv
// kd_tree_sched: sequences one KD-tree run.
//   IDLE  -> wait for start, latch query count.
//   LOAD  -> stream NUM_NODE_WORDS aggregator words into the tree's node storage.
//   QUERY -> issue query patches into the tree pipeline. Issue is credit-gated
//            so that every result has a guaranteed slot in the result FIFO.
//   DRAIN -> wait until no results are in flight and the FIFO has been read out.
//   DONE  -> one-cycle done pulse, then back to IDLE.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, num_queries               run request / query count (IDLE only)
//   node_data/valid/ready            aggregator word stream (consumed in LOAD)
//   query_patch/valid/ready          query source stream (consumed in QUERY)
//   tree_fsm_enable                  tree enable (LOAD/QUERY/DRAIN)
//   tree_sender_enable/data          node write strobe + word to the tree
//   tree_patch_in                    registered patch to the tree
//   tree_leaf_index                  leaf index returned TREE_LATENCY cycles later
//   res_leaf/valid/ready             show-ahead result FIFO output
//   busy, done                       status
module kd_tree_sched #(
  parameter int DSIZE          = 11,
  parameter int FETCH_WIDTH    = 2,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int NUM_NODE_WORDS = 255,
  parameter int TREE_LATENCY   = 8,
  parameter int RESULT_DEPTH   = 16,
  parameter int QCOUNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [QCOUNT_WIDTH-1:0]      num_queries,
  input  logic [FETCH_WIDTH*DSIZE-1:0] node_data,
  input  logic                         node_valid,
  output logic                         node_ready,
  input  logic [PATCH_WIDTH-1:0]       query_patch,
  input  logic                         query_valid,
  output logic                         query_ready,
  output logic                         tree_fsm_enable,
  output logic                         tree_sender_enable,
  output logic [FETCH_WIDTH*DSIZE-1:0] tree_sender_data,
  output logic [PATCH_WIDTH-1:0]       tree_patch_in,
  input  logic [ADDRESS_WIDTH-1:0]     tree_leaf_index,
  output logic [ADDRESS_WIDTH-1:0]     res_leaf,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int NCW  = $clog2(NUM_NODE_WORDS + 1);
  localparam int PTRW = $clog2(RESULT_DEPTH);
  localparam int CNTW = $clog2(RESULT_DEPTH + 1);
  localparam int IFW  = $clog2(TREE_LATENCY + 1);
  localparam int SUMW = CNTW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QUERY, S_DRAIN, S_DONE} state_t;

  state_t                                  r_state, w_state_nxt;
  logic [QCOUNT_WIDTH-1:0]                 r_qremain;
  logic [NCW-1:0]                          r_node_cnt;
  logic [TREE_LATENCY-1:0]                 r_vld_pipe, w_pipe_nxt;
  logic [IFW-1:0]                          r_inflight;
  logic [RESULT_DEPTH-1:0][ADDRESS_WIDTH-1:0] r_mem;
  logic [PTRW-1:0]                         r_wptr, r_rptr;
  logic [CNTW-1:0]                         r_count;

  logic w_start, w_node_hs, w_last_node, w_q_hs, w_credit, w_push, w_pop;

  assign w_start     = (r_state == S_IDLE) & start;
  assign w_node_hs   = (r_state == S_LOAD) & node_valid;
  assign w_last_node = r_node_cnt == NCW'(NUM_NODE_WORDS - 1);
  // Credit: every issued query owns a FIFO slot from issue until it is popped.
  assign w_credit    = (SUMW'(r_count) + SUMW'(r_inflight)) < SUMW'(RESULT_DEPTH);
  assign w_q_hs      = query_ready & query_valid;
  assign w_push      = r_vld_pipe[TREE_LATENCY-1];
  assign w_pop       = res_valid & res_ready;

  assign node_ready         = (r_state == S_LOAD);
  assign tree_sender_enable = w_node_hs;
  assign tree_sender_data   = node_data;
  assign query_ready        = (r_state == S_QUERY) & (r_qremain != '0) & w_credit;
  assign tree_fsm_enable    = (r_state == S_LOAD) | (r_state == S_QUERY) | (r_state == S_DRAIN);
  assign busy               = (r_state != S_IDLE);
  assign done               = (r_state == S_DONE);
  assign res_valid          = (r_count != '0);
  assign res_leaf           = r_mem[r_rptr];

  always_comb begin
    w_pipe_nxt    = r_vld_pipe << 1;
    w_pipe_nxt[0] = w_q_hs;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_node_hs && w_last_node)
                 w_state_nxt = (r_qremain == '0) ? S_DRAIN : S_QUERY;
      S_QUERY: if (w_q_hs && r_qremain == QCOUNT_WIDTH'(1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_inflight == '0 && r_count == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_qremain     <= '0;
      r_node_cnt    <= '0;
      r_vld_pipe    <= '0;
      r_inflight    <= '0;
      tree_patch_in <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vld_pipe <= w_pipe_nxt;
      r_inflight <= r_inflight + IFW'(w_q_hs) - IFW'(w_push);
      if (w_start) begin
        r_qremain  <= num_queries;
        r_node_cnt <= '0;
      end else begin
        if (w_node_hs) r_node_cnt <= r_node_cnt + NCW'(1);
        if (w_q_hs)    r_qremain  <= r_qremain - QCOUNT_WIDTH'(1);
      end
      if (w_q_hs) tree_patch_in <= query_patch;
    end
  end

  // Result FIFO. Full-with-push cannot happen because of the issue credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= tree_leaf_index;
        r_wptr        <= r_wptr + PTRW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTRW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
